control_sequencer: RTL and testbench

- Microcoded-FSM control unit that drives every control input of the 8-bit CPU datapath: register read/write strobes, PC count/load/drive, MAR load, memory strobes, ALU opcode/select/flag controls.
- Consumes the instruction register contents and ALU flags.
- Sequences fetch, decode and execute so that exactly one source drives the shared 8-bit data bus per cycle.

---
 rtl/cpu_8bit_pkg.sv | 55 +++++
 rtl/ctrl_word_decode.sv | 62 ++++++
 rtl/control_sequencer.sv | 92 +++++++++
 tb/tb_control_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_8bit_pkg.sv
// cpu_8bit_pkg: opcodes, sequencer states and the control word shared by the control unit
package cpu_8bit_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_LDB = 4'h2,
        OP_STA = 4'h3,
        OP_ALU = 4'h4,
        OP_JMP = 4'h5,
        OP_JZ  = 4'h6,
        OP_JC  = 4'h7,
        OP_LDI = 4'h8,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [3:0] {
        RST, FETCH_A, FETCH_D, DECODE, OPA_A, OPA_D,
        EXEC_LD, EXEC_ST, EXEC_ALU, IMM, JUMP, SKIP, HALT
    } state_t;

    typedef struct packed {
        logic       a_wrtn;
        logic       a_rdn;
        logic       b_wrtn;
        logic       b_rdn;
        logic       ir_wrtn;
        logic       ir_rdn;
        logic       mar_wrtn;
        logic       mem_rdn;
        logic       mem_wrtn;
        logic       pc_cntn;
        logic       pc_den;
        logic       pc_din;
        logic [3:0] alu_opcode;
        logic       cin;
        logic       alu_sel;
        logic       alu_flag_sel;
        logic       halted;
        logic       illegal;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '{
        a_wrtn: 1'b1, a_rdn: 1'b1, b_wrtn: 1'b1, b_rdn: 1'b1,
        ir_wrtn: 1'b1, ir_rdn: 1'b1, mar_wrtn: 1'b1, mem_rdn: 1'b1,
        mem_wrtn: 1'b1, pc_cntn: 1'b1, pc_den: 1'b0, pc_din: 1'b0,
        alu_opcode: 4'h0, cin: 1'b0, alu_sel: 1'b0, alu_flag_sel: 1'b0,
        halted: 1'b0, illegal: 1'b0
    };

    function automatic logic is_illegal(input logic [3:0] op);
        return op inside {[4'h9:4'hE]};
    endfunction

endpackage

// File: rtl/ctrl_word_decode.sv
// ctrl_word_decode: control word asserted while the sequencer occupies a given state
module ctrl_word_decode
    import cpu_8bit_pkg::*;
(
    input  state_t     state,
    input  logic [7:0] ir,
    output ctrl_word_t ctrl
);

    opcode_t op;
    assign op = opcode_t'(ir[7:4]);

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            FETCH_A, OPA_A: begin
                ctrl.pc_den   = 1'b1;
                ctrl.mar_wrtn = 1'b0;
            end
            FETCH_D: begin
                ctrl.mem_rdn = 1'b0;
                ctrl.ir_wrtn = 1'b0;
                ctrl.pc_cntn = 1'b0;
            end
            DECODE: ctrl.illegal = is_illegal(ir[7:4]);
            OPA_D: begin
                ctrl.mem_rdn  = 1'b0;
                ctrl.mar_wrtn = 1'b0;
                ctrl.pc_cntn  = 1'b0;
            end
            EXEC_LD: begin
                ctrl.mem_rdn = 1'b0;
                ctrl.a_wrtn  = op != OP_LDA;
                ctrl.b_wrtn  = op == OP_LDA;
            end
            EXEC_ST: begin
                ctrl.a_rdn    = 1'b0;
                ctrl.mem_wrtn = 1'b0;
            end
            EXEC_ALU: begin
                ctrl.alu_sel      = 1'b1;
                ctrl.a_wrtn       = 1'b0;
                ctrl.alu_flag_sel = 1'b1;
                ctrl.alu_opcode   = ir[3:0];
                ctrl.cin          = 1'b0;
            end
            IMM: begin
                ctrl.mem_rdn = 1'b0;
                ctrl.a_wrtn  = 1'b0;
                ctrl.pc_cntn = 1'b0;
            end
            JUMP: begin
                ctrl.mem_rdn = 1'b0;
                ctrl.pc_din  = 1'b1;
            end
            SKIP: ctrl.pc_cntn = 1'b0;
            HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute FSM driving every datapath control strobe
module control_sequencer
    import cpu_8bit_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_ir_data,
    input  logic       i_zr,
    input  logic       i_co,
    output logic       o_a_wrtn,
    output logic       o_a_rdn,
    output logic       o_b_wrtn,
    output logic       o_b_rdn,
    output logic       o_ir_wrtn,
    output logic       o_ir_rdn,
    output logic       o_mar_wrtn,
    output logic       o_mem_rdn,
    output logic       o_mem_wrtn,
    output logic       o_pc_cntn,
    output logic       o_pc_den,
    output logic       o_pc_din,
    output logic [3:0] o_alu_opcode,
    output logic       o_cin,
    output logic       o_alu_sel,
    output logic       o_alu_flag_sel,
    output logic       o_halted,
    output logic       o_illegal
);

    state_t     state, state_nx;
    ctrl_word_t ctrl, ctrl_nx;
    opcode_t    op;

    assign op = opcode_t'(i_ir_data[7:4]);

    always_comb begin
        state_nx = FETCH_A;
        case (state)
            FETCH_A: state_nx = FETCH_D;
            FETCH_D: state_nx = DECODE;
            DECODE: begin
                case (op)
                    OP_NOP:                                 state_nx = FETCH_A;
                    OP_LDA, OP_LDB, OP_STA, OP_JMP, OP_LDI: state_nx = OPA_A;
                    OP_ALU:                                 state_nx = EXEC_ALU;
                    OP_JZ:                                  state_nx = i_zr ? OPA_A : SKIP;
                    OP_JC:                                  state_nx = i_co ? OPA_A : SKIP;
                    OP_HLT:                                 state_nx = HALT;
                    default:                                state_nx = ILLEGAL_HALT ? HALT : FETCH_A;
                endcase
            end
            OPA_A: state_nx = (op inside {OP_LDA, OP_LDB, OP_STA}) ? OPA_D : (op == OP_LDI) ? IMM : JUMP;
            OPA_D: state_nx = (op == OP_STA) ? EXEC_ST : EXEC_LD;
            HALT:  state_nx = HALT;
            default: state_nx = FETCH_A;
        endcase
    end

    // Decoding the next state lets the registered word line up with the state it belongs to.
    ctrl_word_decode u_decode (
        .state (state_nx),
        .ir    (i_ir_data),
        .ctrl  (ctrl_nx)
    );

    always_ff @(posedge i_clk) begin
        state <= i_rst ? RST : state_nx;
        ctrl  <= i_rst ? CTRL_IDLE : ctrl_nx;
    end

    assign o_a_wrtn       = ctrl.a_wrtn;
    assign o_a_rdn        = ctrl.a_rdn;
    assign o_b_wrtn       = ctrl.b_wrtn;
    assign o_b_rdn        = ctrl.b_rdn;
    assign o_ir_wrtn      = ctrl.ir_wrtn;
    assign o_ir_rdn       = ctrl.ir_rdn;
    assign o_mar_wrtn     = ctrl.mar_wrtn;
    assign o_mem_rdn      = ctrl.mem_rdn;
    assign o_mem_wrtn     = ctrl.mem_wrtn;
    assign o_pc_cntn      = ctrl.pc_cntn;
    assign o_pc_den       = ctrl.pc_den;
    assign o_pc_din       = ctrl.pc_din;
    assign o_alu_opcode   = ctrl.alu_opcode;
    assign o_cin          = ctrl.cin;
    assign o_alu_sel      = ctrl.alu_sel;
    assign o_alu_flag_sel = ctrl.alu_flag_sel;
    assign o_halted       = ctrl.halted;
    assign o_illegal      = ctrl.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard of per-cycle control words for directed instruction streams
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ir  = 8'h00;
    logic       zr  = 1'b0;
    logic       co  = 1'b0;
    logic       a_wrtn, a_rdn, b_wrtn, b_rdn, ir_wrtn, ir_rdn, mar_wrtn;
    logic       mem_rdn, mem_wrtn, pc_cntn, pc_den, pc_din;
    logic [3:0] alu_opcode;
    logic       cin, alu_sel, alu_flag_sel, halted, illegal;

    always #5 clk = ~clk;

    control_sequencer #(.ILLEGAL_HALT(1'b0)) dut (
        .i_clk(clk), .i_rst(rst), .i_ir_data(ir), .i_zr(zr), .i_co(co),
        .o_a_wrtn(a_wrtn), .o_a_rdn(a_rdn), .o_b_wrtn(b_wrtn), .o_b_rdn(b_rdn),
        .o_ir_wrtn(ir_wrtn), .o_ir_rdn(ir_rdn), .o_mar_wrtn(mar_wrtn),
        .o_mem_rdn(mem_rdn), .o_mem_wrtn(mem_wrtn), .o_pc_cntn(pc_cntn),
        .o_pc_den(pc_den), .o_pc_din(pc_din), .o_alu_opcode(alu_opcode),
        .o_cin(cin), .o_alu_sel(alu_sel), .o_alu_flag_sel(alu_flag_sel),
        .o_halted(halted), .o_illegal(illegal)
    );

    logic [20:0] obs;
    assign obs = {a_wrtn, a_rdn, b_wrtn, b_rdn, ir_wrtn, ir_rdn, mar_wrtn, mem_rdn, mem_wrtn,
                  pc_cntn, pc_den, pc_din, alu_opcode, cin, alu_sel, alu_flag_sel, halted, illegal};

    // Each mask flips one signal from its idle level to its active level.
    localparam logic [20:0] AW = 21'h1 << 20, AR = 21'h1 << 19, BW = 21'h1 << 18;
    localparam logic [20:0] IW = 21'h1 << 16, MW = 21'h1 << 14, MR = 21'h1 << 13;
    localparam logic [20:0] MWR = 21'h1 << 12, PC = 21'h1 << 11, PD = 21'h1 << 10;
    localparam logic [20:0] PDIN = 21'h1 << 9, ASEL = 21'h1 << 3, FSEL = 21'h1 << 2;
    localparam logic [20:0] HLTD = 21'h1 << 1, ILL = 21'h1;
    localparam logic [20:0] IDLE = 21'h1FF800;
    localparam logic [20:0] FA = IDLE ^ (PD | MW), FD = IDLE ^ (MR | IW | PC);
    localparam logic [20:0] OD = IDLE ^ (MR | MW | PC), SKP = IDLE ^ PC;
    localparam logic [20:0] JMP = IDLE ^ (MR | PDIN), IMM = IDLE ^ (MR | AW | PC);
    localparam logic [20:0] LDA = IDLE ^ (MR | AW), LDB = IDLE ^ (MR | BW);
    localparam logic [20:0] STA = IDLE ^ (AR | MWR), HLT = IDLE ^ HLTD;

    logic [20:0] sb[$];
    int  n_cmp = 0, n_bad = 0;
    bit  inv_en = 1'b0;
    int  drv;
    logic ld;

    task automatic check(input string tag, input logic [20:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_instr(input logic [7:0] v, input logic z, input logic c);
        logic [3:0] op;
        op = v[7:4];
        sb.push_back(FA);
        sb.push_back(FD);
        case (op)
            4'h0: sb.push_back(IDLE);
            4'h1, 4'h2, 4'h3: begin
                sb.push_back(IDLE);
                sb.push_back(FA);
                sb.push_back(OD);
                sb.push_back(op == 4'h1 ? LDA : op == 4'h2 ? LDB : STA);
            end
            4'h4: begin
                sb.push_back(IDLE);
                sb.push_back((IDLE ^ (ASEL | FSEL | AW)) | (21'(v[3:0]) << 5));
            end
            4'h5: begin
                sb.push_back(IDLE);
                sb.push_back(FA);
                sb.push_back(JMP);
            end
            4'h6, 4'h7: begin
                sb.push_back(IDLE);
                if ((op == 4'h6) ? z : c) begin
                    sb.push_back(FA);
                    sb.push_back(JMP);
                end else sb.push_back(SKP);
            end
            4'h8: begin
                sb.push_back(IDLE);
                sb.push_back(FA);
                sb.push_back(IMM);
            end
            4'hF: begin
                sb.push_back(IDLE);
                for (int i = 0; i < 5; i++) sb.push_back(HLT);
            end
            default: sb.push_back(IDLE ^ ILL);
        endcase
    endtask

    task automatic go(input string tag, input logic [7:0] v, input logic z, input logic c);
        @(negedge clk);
        ir = v;
        zr = z;
        co = c;
        check(tag, sb.pop_front());
        while (sb.size() > 0) begin
            @(negedge clk);
            check(tag, sb.pop_front());
        end
    endtask

    task automatic run(input string tag, input logic [7:0] v, input logic z, input logic c);
        expect_instr(v, z, c);
        go(tag, v, z, c);
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, IDLE);
        end
    endtask

    always @(negedge clk) begin
        if (inv_en) begin
            drv = $countones({pc_den, ~mem_rdn, ~a_rdn, ~b_rdn, ~ir_rdn, alu_sel});
            ld  = |{~a_wrtn, ~b_wrtn, ~ir_wrtn, ~mar_wrtn, ~mem_wrtn, pc_din};
            n_cmp++;
            assert (drv <= 1 && (!ld || drv == 1)) else begin
                n_bad++;
                $error("FAIL bus_driver: drivers %0d load %0b word %h", drv, ld, obs);
            end
        end
    end

    initial begin
        idle_cycles("reset", 2);
        inv_en = 1'b1;
        rst = 1'b0;
        run("nop0", 8'h00, 1'b0, 1'b0);
        run("nop1", 8'h00, 1'b0, 1'b0);
        run("lda", 8'h10, 1'b0, 1'b0);
        run("ldb", 8'h20, 1'b0, 1'b0);
        run("sta", 8'h30, 1'b0, 1'b0);
        run("alu_a", 8'h4A, 1'b0, 1'b0);
        run("alu_3", 8'h43, 1'b0, 1'b0);
        run("jmp", 8'h50, 1'b0, 1'b0);
        run("jz_taken", 8'h60, 1'b1, 1'b0);
        run("jz_not", 8'h60, 1'b0, 1'b1);
        run("jc_taken", 8'h70, 1'b0, 1'b1);
        run("jc_not", 8'h70, 1'b1, 1'b0);
        run("ldi", 8'h80, 1'b0, 1'b0);
        run("illegal9", 8'h90, 1'b0, 1'b0);
        run("illegalE", 8'hE5, 1'b0, 1'b0);
        run("after_ill", 8'h00, 1'b0, 1'b0);
        sb.push_back(FA);
        sb.push_back(FD);
        sb.push_back(IDLE);
        sb.push_back(FA);
        sb.push_back(OD);
        go("lda_abort", 8'h10, 1'b0, 1'b0);
        rst = 1'b1;
        idle_cycles("mid_reset", 3);
        rst = 1'b0;
        run("post_reset", 8'h10, 1'b0, 1'b0);
        run("halt", 8'hF0, 1'b0, 1'b0);
        rst = 1'b1;
        idle_cycles("halt_reset", 2);
        rst = 1'b0;
        run("recover", 8'h00, 1'b0, 1'b0);
        inv_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
